// File: rtl/fir_out_pkg.sv
// rtl/fir_out_pkg.sv - shared widths and parameter defaults for the FIR output FIFO
package fir_out_pkg;
  localparam int FIR_W     = 16;
  localparam int DEPTH_DEF = 8;
  localparam int SHIFT_DEF = 4;
  localparam int OUT_W_DEF = 8;
endpackage

// File: rtl/fir_out_fifo_if.sv
// rtl/fir_out_fifo_if.sv - raw FIR sample in, rounded/clipped sample out of the round/saturate stage
interface fir_out_fifo_if import fir_out_pkg::*; #(
  parameter int OUT_W = OUT_W_DEF
);
  logic [FIR_W-1:0] fir;
  logic [OUT_W-1:0] sample;
  logic             sat;

  modport master (output fir, input sample, input sat);
  modport slave  (input fir, output sample, output sat);
endinterface

// File: rtl/fir_out_rndsat.sv
// rtl/fir_out_rndsat.sv - round half toward +inf, arithmetic shift, clip to OUT_W signed
module fir_out_rndsat import fir_out_pkg::*; #(
  parameter int SHIFT = SHIFT_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  fir_out_fifo_if.slave rs
);
  localparam int RND_I     = 1 << (SHIFT - 1);
  localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN_I = -(1 << (OUT_W - 1));
  localparam logic signed [FIR_W:0] RND     = RND_I[FIR_W:0];
  localparam logic signed [FIR_W:0] SAT_MAX = SAT_MAX_I[FIR_W:0];
  localparam logic signed [FIR_W:0] SAT_MIN = SAT_MIN_I[FIR_W:0];

  // One guard bit is enough: max positive input plus the rounding constant still fits
  logic signed [FIR_W:0] w_ext;
  logic signed [FIR_W:0] w_sum;
  logic signed [FIR_W:0] w_shr;
  logic [OUT_W-1:0]      w_sample;
  logic                  w_sat;

  assign w_ext = {rs.fir[FIR_W-1], rs.fir};
  assign w_sum = w_ext + RND;
  assign w_shr = w_sum >>> SHIFT;

  always_comb begin
    w_sat    = 1'b0;
    w_sample = w_shr[OUT_W-1:0];
    if (w_shr > SAT_MAX) begin
      w_sat    = 1'b1;
      w_sample = SAT_MAX[OUT_W-1:0];
    end else if (w_shr < SAT_MIN) begin
      w_sat    = 1'b1;
      w_sample = SAT_MIN[OUT_W-1:0];
    end
  end

  assign rs.sample = w_sample;
  assign rs.sat    = w_sat;
endmodule

// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - two-stage capture of FIR output samples into a no-fall-through FIFO
module fir_out_fifo import fir_out_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                     iClk_12MHz,
  input  logic                     iRst,
  input  logic                     iEnSample_600kHz,
  input  logic [FIR_W-1:0]         iFirOut,
  input  logic                     iRdReady,
  output logic                     oRdValid,
  output logic [OUT_W-1:0]         oRdData,
  output logic                     oSatPulse,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic [7:0]               oDropCnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic             r_s1_vld;
  logic             r_s2_vld;
  logic             r_s2_sat;
  logic [OUT_W-1:0] r_s2_data;
  logic             r_sat_pulse;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [7:0]       r_drop_cnt;
  logic [OUT_W-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  fir_out_fifo_if #(.OUT_W(OUT_W)) w_rs ();
  assign w_rs.fir = iFirOut;

  fir_out_rndsat #(.SHIFT(SHIFT), .OUT_W(OUT_W)) u_rndsat (.rs(w_rs));

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = !w_empty && iRdReady;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write
  assign w_push  = r_s2_vld && (!w_full || w_pop);
  assign w_drop  = r_s2_vld && w_full && !w_pop;

  always_ff @(posedge iClk_12MHz) begin
    if (iRst) begin
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_s2_sat    <= 1'b0;
      r_s2_data   <= '0;
      r_sat_pulse <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_s1_vld    <= iEnSample_600kHz;
      r_s2_vld    <= r_s1_vld;
      r_s2_sat    <= r_s1_vld && w_rs.sat;
      r_s2_data   <= w_rs.sample;
      r_sat_pulse <= r_s2_vld && r_s2_sat;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge iClk_12MHz) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_s2_data;
  end

  assign oRdValid  = !w_empty;
  assign oRdData   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign oSatPulse = r_sat_pulse;
  assign oLevel    = r_wr_ptr - r_rd_ptr;
  assign oDropCnt  = r_drop_cnt;
endmodule

// File: tb/tb_fir_out_fifo.sv
// tb/tb_fir_out_fifo.sv - scoreboard bench for fir_out_fifo
module tb_fir_out_fifo;
  import fir_out_pkg::*;

  localparam int DEPTH = 8;

  logic        iClk_12MHz = 1'b0;
  logic        iRst = 1'b1;
  logic        iEnSample_600kHz = 1'b0;
  logic [15:0] iFirOut = '0;
  logic        iRdReady = 1'b0;
  logic        oRdValid;
  logic [7:0]  oRdData;
  logic        oSatPulse;
  logic [3:0]  oLevel;
  logic [7:0]  oDropCnt;

  int n_vec = 0;
  int n_err = 0;
  int sat_seen = 0;
  int sat_exp = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] stim_q[$];

  fir_out_fifo #(.DEPTH(DEPTH), .SHIFT(4), .OUT_W(8)) dut (
    .iClk_12MHz       (iClk_12MHz),
    .iRst             (iRst),
    .iEnSample_600kHz (iEnSample_600kHz),
    .iFirOut          (iFirOut),
    .iRdReady         (iRdReady),
    .oRdValid         (oRdValid),
    .oRdData          (oRdData),
    .oSatPulse        (oSatPulse),
    .oLevel           (oLevel),
    .oDropCnt         (oDropCnt)
  );

  always #5 iClk_12MHz = ~iClk_12MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // floor((v + 8) / 16) written as division with a floor correction for negatives
  function automatic int rnd_floor(input logic [15:0] v);
    int s;
    int q;
    s = int'($signed(v)) + 8;
    q = s / 16;
    if (s < 0 && (s % 16) != 0) q = q - 1;
    return q;
  endfunction

  always @(negedge iClk_12MHz) begin
    if (!iRst) begin
      if (oSatPulse) sat_seen++;
      if (oRdValid && iRdReady) begin
        if (exp_q.size() == 0) chk("unexpected_pop", {24'h0, oRdData}, 32'hDEAD);
        else chk("rd_data", {24'h0, oRdData}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic burst(input bit force_push);
    int n;
    n = stim_q.size();
    for (int i = 0; i <= n; i++) begin
      @(posedge iClk_12MHz); #1;
      iEnSample_600kHz = (i < n);
      if (i > 0) iFirOut = stim_q[i-1];
      if (i < n) begin
        int r;
        logic [31:0] ru;
        r = rnd_floor(stim_q[i]);
        if (r > 127) begin r = 127; sat_exp++; end
        else if (r < -128) begin r = -128; sat_exp++; end
        ru = r;
        if (force_push || exp_q.size() < DEPTH) exp_q.push_back(ru[7:0]);
      end
    end
    stim_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iClk_12MHz); #1;
    end
  endtask

  task automatic drain(input string tag);
    iRdReady = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
      @(posedge iClk_12MHz); #1;
    end
    @(posedge iClk_12MHz); #1;
    chk({tag, "_left"}, exp_q.size(), 0);
    @(negedge iClk_12MHz);
    chk({tag, "_empty"}, {31'h0, oRdValid}, 0);
    chk({tag, "_level"}, {28'h0, oLevel}, 0);
    @(posedge iClk_12MHz); #1;
    iRdReady = 1'b0;
  endtask

  initial begin
    idle(2);
    @(negedge iClk_12MHz);
    chk("rst_valid", {31'h0, oRdValid}, 0);
    chk("rst_level", {28'h0, oLevel}, 0);
    chk("rst_drop",  {24'h0, oDropCnt}, 0);
    chk("rst_data",  {24'h0, oRdData}, 0);
    chk("rst_sat",   {31'h0, oSatPulse}, 0);
    @(posedge iClk_12MHz); #1;
    iRst = 1'b0;
    idle(2);

    // latency: strobe in N, visible in N+3
    @(posedge iClk_12MHz); #1;
    iEnSample_600kHz = 1'b1;
    exp_q.push_back(8'h05);
    @(posedge iClk_12MHz); #1;
    iEnSample_600kHz = 1'b0;
    iFirOut = 16'h0050;
    @(negedge iClk_12MHz);
    chk("lat_n1", {31'h0, oRdValid}, 0);
    @(negedge iClk_12MHz);
    chk("lat_n2", {31'h0, oRdValid}, 0);
    @(negedge iClk_12MHz);
    chk("lat_n3_valid", {31'h0, oRdValid}, 1);
    chk("lat_n3_level", {28'h0, oLevel}, 1);
    drain("lat");

    // rounding
    stim_q = '{16'h0120, 16'h0008, 16'h0007, 16'hFFE8};
    burst(1'b0);
    idle(4);
    chk("rnd_level", {28'h0, oLevel}, 4);
    drain("rnd");
    chk("rnd_sat", sat_seen, 0);

    // saturation
    stim_q = '{16'h7FFF, 16'h8000};
    burst(1'b0);
    idle(4);
    drain("sat");
    chk("sat_count", sat_seen, sat_exp);
    chk("sat_two", sat_exp, 2);

    // overflow: 10 back-to-back strobes into an 8-deep FIFO
    for (int k = 1; k <= 10; k++) stim_q.push_back(16'(16 * k));
    burst(1'b0);
    idle(4);
    chk("ovf_level", {28'h0, oLevel}, 8);
    chk("ovf_drop",  {24'h0, oDropCnt}, 2);
    chk("ovf_head",  {24'h0, oRdData}, 8'h01);
    drain("ovf");

    // full with simultaneous write and pop
    for (int k = 11; k <= 18; k++) stim_q.push_back(16'(16 * k));
    burst(1'b0);
    idle(4);
    chk("full_level", {28'h0, oLevel}, 8);
    stim_q = '{16'h0300};
    @(posedge iClk_12MHz); #1;
    iEnSample_600kHz = 1'b1;
    exp_q.push_back(8'h30);
    @(posedge iClk_12MHz); #1;
    iEnSample_600kHz = 1'b0;
    iFirOut = 16'h0300;
    @(posedge iClk_12MHz); #1;
    iRdReady = 1'b1;
    @(posedge iClk_12MHz); #1;
    iRdReady = 1'b0;
    @(negedge iClk_12MHz);
    chk("fwp_level", {28'h0, oLevel}, 8);
    chk("fwp_drop",  {24'h0, oDropCnt}, 2);
    stim_q.delete();
    drain("fwp");

    // reset mid-operation with a sample in flight and a strobe during reset
    for (int k = 1; k <= 5; k++) stim_q.push_back(16'(16 * k));
    burst(1'b0);
    idle(4);
    chk("mid_level_pre", {28'h0, oLevel}, 5);
    @(posedge iClk_12MHz); #1;
    iEnSample_600kHz = 1'b1;
    @(posedge iClk_12MHz); #1;
    iFirOut = 16'h0700;
    iRst = 1'b1;
    @(posedge iClk_12MHz); #1;
    iRst = 1'b0;
    iEnSample_600kHz = 1'b0;
    exp_q.delete();
    @(negedge iClk_12MHz);
    chk("mid_level", {28'h0, oLevel}, 0);
    chk("mid_valid", {31'h0, oRdValid}, 0);
    chk("mid_drop",  {24'h0, oDropCnt}, 0);
    chk("mid_data",  {24'h0, oRdData}, 0);
    idle(6);
    @(negedge iClk_12MHz);
    chk("mid_late_level", {28'h0, oLevel}, 0);
    chk("mid_late_sat", sat_seen, sat_exp);

    // empty with ready high: nothing moves
    iRdReady = 1'b1;
    idle(3);
    @(negedge iClk_12MHz);
    chk("empty_rdy_level", {28'h0, oLevel}, 0);
    iRdReady = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fir_out_fifo.md
FIR_OUT_FIFO -- requirements
Module: fir_out_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 4 to 64.
REQ-002 Parameter SHIFT, default 4, right-shift applied to the FIR result before saturation; 1 to 8.
REQ-003 Parameter OUT_W, default 8, signed output sample width.
REQ-004 Port iClk_12MHz  in  1  sole clock; all logic on its rising edge.
REQ-005 Port iRst  in  1  reset, synchronous, active-high.
REQ-006 Port iEnSample_600kHz  in  1  one-clock strobe marking an FIR output update.
REQ-007 Port iFirOut  in  16  FIR filter output, signed two's complement.
REQ-008 Port iRdReady  in  1  consumer ready.
REQ-009 Port oRdValid  out  1  FIFO non-empty, head sample available.
REQ-010 Port oRdData  out  OUT_W  head sample, signed.
REQ-011 Port oSatPulse  out  1  one-clock pulse when a written sample was saturated.
REQ-012 Port oLevel  out  clog2(DEPTH)+1  current occupancy.
REQ-013 Port oDropCnt  out  8  count of samples dropped on full; saturates at 255.

Function
REQ-014 Strobe registered once (stage S1); iFirOut captured in the cycle after the strobe, so the filter's registered output has settled.
REQ-015 Capture path: sign-extend to 17 bits, add 2^(SHIFT-1), arithmetic right shift by SHIFT (round half toward +inf), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-016 Saturated value and write-enable registered (stage S2); write into FIFO at end of S2.
REQ-017 Latency: strobe in cycle N -> entry present, oRdValid high, oLevel incremented in cycle N+3 (at edge ending N+2).
REQ-018 oSatPulse high exactly in the cycle the clipped sample enters the FIFO (N+3), also when that sample is dropped.
REQ-019 Read handshake: pop occurs on a rising edge where oRdValid and iRdReady are both high.
REQ-020 oRdData equals mem[rd_ptr] whenever oRdValid is high; held stable while oRdValid is high and iRdReady is low.
REQ-021 No fall-through: write into an empty FIFO raises oRdValid only in the following cycle.
REQ-022 Full and write without pop: sample dropped, contents unchanged, oDropCnt increments unless at 255.
REQ-023 Full with simultaneous write and pop: both performed, oLevel stays DEPTH, no drop.
REQ-024 Empty with iRdReady high: no pop, pointers unchanged.
REQ-025 Pointers carry one extra wrap bit; full = indices equal and wrap bits differ; empty = pointers equal.
REQ-026 Strobes in consecutive cycles are each captured; no strobe is lost in the pipeline.

Reset
REQ-027 While iRst is high at an edge: pointers, S1/S2 registers, oDropCnt clear; oRdValid=0, oSatPulse=0, oLevel=0, oRdData=0.
REQ-028 Reset mid-operation discards FIFO contents and any in-flight S1/S2 sample; strobes present during reset are ignored.
REQ-029 Memory array is not reset; oRdData is forced to 0 while empty.

Structure
REQ-030 Shared package fir_out_pkg holds the defaults for DEPTH, SHIFT and OUT_W, plus the FIR output width constant (16).
REQ-031 Round/saturate logic goes in the combinational sub-module fir_out_rndsat; the FIFO storage and pointers stay in fir_out_fifo.

Verification
REQ-032 Rounding, SHIFT=4: iFirOut 0x0120 -> 0x12; 0x0008 -> 0x01; 0x0007 -> 0x00; 0xFFE8 -> 0xFF; oSatPulse stays 0.
REQ-033 Saturation: iFirOut 0x7FFF -> 0x7F; 0x8000 -> 0x80; oSatPulse pulses once per sample.
REQ-034 Latency: strobe at cycle 10 with iRdReady=0 -> oRdValid rises at cycle 13, oLevel=1.
REQ-035 Overflow: 10 strobes, samples 1..10 in hardware units (iFirOut 0x0010*k), iRdReady=0:
 - oLevel reaches 8, oDropCnt=2.
 - Draining then yields 0x01..0x08 in order, then oRdValid=0.
REQ-036 Full with simultaneous write and pop: oLevel stays 8, oDropCnt unchanged, new sample appears last.
REQ-037 Reset mid-operation: iRst asserted for 1 cycle with 5 entries and 1 sample in flight -> next cycle oLevel=0, oRdValid=0, oDropCnt=0, and no late write appears.
